// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StWrite
  } state_e;

  function automatic int unsigned calc_offset_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned calc_tag_width(input int unsigned address_width,
                                                 input int unsigned set_width,
                                                 input int unsigned data_width);
    return address_width - set_width - calc_offset_width(data_width);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: asynchronous read, one byte-enabled write port, single-cycle clear of V.
module dcache_array #(
  parameter int unsigned SetWidth  = 3,
  parameter int unsigned TagWidth  = 27,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic [SetWidth-1:0]    i_rd_set,
  output logic                   o_rd_valid,
  output logic [TagWidth-1:0]    o_rd_tag,
  output logic [DataWidth-1:0]   o_rd_data,
  input  logic                   i_wr_en,
  input  logic [SetWidth-1:0]    i_wr_set,
  input  logic [TagWidth-1:0]    i_wr_tag,
  input  logic [DataWidth-1:0]   i_wr_data,
  input  logic [DataWidth/8-1:0] i_wr_be
);

  localparam int unsigned Sets    = 1 << SetWidth;
  localparam int unsigned BeWidth = DataWidth / 8;

  logic [Sets-1:0]      r_valid;
  logic [TagWidth-1:0]  r_tag  [Sets];
  logic [DataWidth-1:0] r_data [Sets];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_set] <= 1'b1;
    end
  end

  // Tag and data are deliberately left unreset; V alone qualifies them.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_set] <= i_wr_tag;
      for (int unsigned b = 0; b < BeWidth; b++) begin
        if (i_wr_be[b]) begin
          r_data[i_wr_set][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  assign o_rd_valid = r_valid[i_rd_set];
  assign o_rd_tag   = r_tag[i_rd_set];
  assign o_rd_data  = r_data[i_rd_set];

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-through, no-write-allocate data cache with hit/miss counters.
module dcache_direct_mapped
  import dcache_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned SET_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]  cpu_be,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  input  logic                     flush,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [DATA_WIDTH/8-1:0]  mem_be,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int unsigned OFFSET_WIDTH = calc_offset_width(DATA_WIDTH);
  localparam int unsigned TAG_WIDTH    = calc_tag_width(ADDRESS_WIDTH, SET_WIDTH, DATA_WIDTH);
  localparam int unsigned BE_WIDTH     = DATA_WIDTH / 8;
  localparam int unsigned TAG_LSB      = OFFSET_WIDTH + SET_WIDTH;

  state_e                   r_state;
  logic                     r_hit;
  logic                     r_mem_req;
  logic                     r_mem_we;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic [BE_WIDTH-1:0]      r_mem_be;
  logic [31:0]              r_hit_count;
  logic [31:0]              r_miss_count;

  logic [SET_WIDTH-1:0]     w_set;
  logic [TAG_WIDTH-1:0]     w_tag;
  logic                     w_rd_valid;
  logic [TAG_WIDTH-1:0]     w_rd_tag;
  logic [DATA_WIDTH-1:0]    w_rd_data;
  logic                     w_hit;
  logic                     w_start;
  logic                     w_ack;
  logic                     w_flush;
  logic                     w_wr_en;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic [BE_WIDTH-1:0]      w_wr_be;
  logic [ADDRESS_WIDTH-1:0] w_aligned;
  logic                     w_unused_offset;

  assign w_set     = cpu_addr[TAG_LSB-1:OFFSET_WIDTH];
  assign w_tag     = cpu_addr[ADDRESS_WIDTH-1:TAG_LSB];
  assign w_aligned = {cpu_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign w_hit     = w_rd_valid && (w_rd_tag == w_tag);
  assign w_start   = (r_state == StIdle) && cpu_req && !flush;
  assign w_flush   = (r_state == StIdle) && flush;
  // An ack without an outstanding request is ignored.
  assign w_ack     = mem_ack && r_mem_req;
  assign w_wr_en   = w_ack && ((r_state == StRefill) || ((r_state == StWrite) && r_hit));
  assign w_wr_data = (r_state == StRefill) ? mem_rdata : r_mem_wdata;
  assign w_wr_be   = (r_state == StRefill) ? {BE_WIDTH{1'b1}} : r_mem_be;

  assign w_unused_offset = ^cpu_addr[OFFSET_WIDTH-1:0];

  dcache_array #(
    .SetWidth (SET_WIDTH),
    .TagWidth (TAG_WIDTH),
    .DataWidth(DATA_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (w_flush),
    .i_rd_set  (w_set),
    .o_rd_valid(w_rd_valid),
    .o_rd_tag  (w_rd_tag),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_set  (r_mem_addr[TAG_LSB-1:OFFSET_WIDTH]),
    .i_wr_tag  (r_mem_addr[ADDRESS_WIDTH-1:TAG_LSB]),
    .i_wr_data (w_wr_data),
    .i_wr_be   (w_wr_be)
  );

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = w_rd_data;
    unique case (r_state)
      StIdle:   cpu_stall = cpu_req && (flush || cpu_we || !w_hit);
      StRefill: begin
        cpu_stall = !w_ack;
        cpu_rdata = mem_rdata;
      end
      StWrite:  cpu_stall = !w_ack;
      default:  cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_hit        <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            if (cpu_we) begin
              r_state     <= StWrite;
              r_hit       <= w_hit;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_aligned;
              r_mem_wdata <= cpu_wdata;
              r_mem_be    <= cpu_be;
            end else if (!w_hit) begin
              r_state     <= StRefill;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= w_aligned;
              r_mem_wdata <= '0;
              r_mem_be    <= {BE_WIDTH{1'b1}};
            end else begin
              r_hit_count <= r_hit_count + 32'd1;
            end
          end
        end
        StRefill, StWrite: begin
          if (w_ack) begin
            r_state     <= StIdle;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            if ((r_state == StWrite) && r_hit) begin
              r_hit_count <= r_hit_count + 32'd1;
            end else begin
              r_miss_count <= r_miss_count + 32'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: doc/dcache_direct_mapped.md
# dcache_direct_mapped

Parametrised direct-mapped, write-through, no-write-allocate data cache between the CPU load/store unit and the data memory port. It holds 2**SET_WIDTH one-word lines, each with a valid bit, a tag and a data word. It serves read hits in zero wait cycles, refills read misses through a request/acknowledge memory handshake, and forwards every store to memory, updating the line on a hit. It also supports a single-cycle flush (invalidate all) and provides hit/miss counters.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, line/word width; multiple of 8
- SET_WIDTH, 3, index bits; sets = 2**SET_WIDTH
- OFFSET_WIDTH, $clog2(DATA_WIDTH/8), byte-offset bits (derived)
- TAG_WIDTH, ADDRESS_WIDTH-SET_WIDTH-OFFSET_WIDTH, tag bits (derived; 27 at defaults)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDRESS_WIDTH  byte address; offset bits ignored
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_be  in  DATA_WIDTH/8  store byte enables
- cpu_rdata  out  DATA_WIDTH  load data; valid when cpu_req & !cpu_we & !cpu_stall
- cpu_stall  out  1  access not complete this cycle
- flush  in  1  invalidate all lines
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDRESS_WIDTH  word-aligned address (offset bits zero)
- mem_wdata  out  DATA_WIDTH  write data
- mem_be  out  DATA_WIDTH/8  byte enables; all ones on refill
- mem_ack  in  1  request completed; mem_rdata valid for reads
- mem_rdata  in  DATA_WIDTH  refill data
- hit_count  out  32  completed hits (load hits and store hits), wraps
- miss_count  out  32  completed misses (refills and store misses), wraps

## Operation
- Address split: set = addr[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH]; tag = addr[ADDRESS_WIDTH-1:OFFSET_WIDTH+SET_WIDTH]; hit = V[set] & (tag match).
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - flush=1: clear all V, no transition. Any cpu_req that cycle sees cpu_stall=1.
  - Otherwise, load hit: cpu_rdata = line data, cpu_stall=0, hit_count+1.
  - Load miss: cpu_stall=1; latch addr → REFILL.
  - Store (hit or miss): cpu_stall=1; latch addr/wdata/be/hit flag → WRITE.
- REFILL: mem_req=1, mem_we=0, mem_be all ones. On mem_ack: write V=1, tag, data=mem_rdata into the set; cpu_rdata=mem_rdata; cpu_stall=0; miss_count+1; → IDLE.
- WRITE: mem_req=1, mem_we=1, latched data/be. On mem_ack: cpu_stall=0. If the latched flag is a hit, merge enabled bytes into the line and increment hit_count. Otherwise the cache is unchanged and miss_count increments. → IDLE.
- flush is honoured only in IDLE; it is ignored in REFILL/WRITE (the CPU must re-assert it).
- The CPU holds cpu_* stable while cpu_stall=1. The cache works from latched copies regardless.

## Timing
- Reset (async, rst_n=0): state IDLE, all V=0, mem_req=0, mem_we=0, mem_addr/wdata/be=0, counters=0, cpu_stall=0 (combinational from IDLE with cpu_req=0). Tag/data arrays are not reset.
- Reset mid-transaction: mem_req drops immediately, and the outstanding mem_ack is ignored after release.
- Load hit: 0 wait cycles.
- Miss or store: request issued the cycle after detection; completes in the mem_ack cycle. Minimum 1 stall cycle if mem_ack is high on the first REFILL/WRITE cycle.
- Handshake: mem_* outputs are registered, stable while mem_req=1, and deasserted in the cycle after mem_ack. mem_ack with mem_req=0 is ignored.
- Back-to-back: a new access may be presented in the cycle after completion; there is no dead cycle beyond the IDLE lookup.
- A store hit followed by a load to the same address returns the merged data.

## Structure
- dcache_pkg: state enum (IDLE, REFILL, WRITE) and the function computing OFFSET_WIDTH/TAG_WIDTH from the parameters.
- Sub-module dcache_array:
  - Storage for V/tag/data.
  - Asynchronous read by set.
  - One synchronous write port with byte-enable merge.
  - Single-cycle clear-all of V under rst_n/flush.
- The top level holds the FSM, latches, counters and the memory interface.

## Test plan
- After reset, load 0x0000_0040 → stall, REFILL; mem_ack after 3 cycles with rdata 0xDEAD_BEEF → cpu_rdata 0xDEAD_BEEF in the ack cycle; repeat load → 0 stalls, hit_count=1, miss_count=1.
- Conflict: loads 0x40 then 0x60 (same set 0, different tag) → both miss; a third load of 0x40 misses again.
- Store 0x40 wdata 0x1122_3344 be 0b0011 after line holds 0xDEAD_BEEF → mem_we=1, mem_be=0011; after ack, load 0x40 hits with 0xDEAD_3344.
- Store miss to 0x80 → memory write only; a following load of 0x80 misses (no allocate).
- flush in IDLE after filling sets 0–7 → all subsequent loads miss; flush asserted during REFILL → ignored, refilled line remains valid.
- rst_n low during REFILL with mem_req=1 → mem_req=0 asynchronously; after release, load of the same address misses.
